// File: rtl/game_flow_ctrl.sv
// Game-state FSM and scorer fed by the stair, monster and bullet collision detectors.
// Optional lives/respawn support is enabled by defining GAME_LIVES_EN.
module game_flow_ctrl #(
    parameter int STAIR_PTS    = 1,
    parameter int MONSTER_PTS  = 10,
    parameter int SCORE_MAX    = 9999,
    parameter int FLOOR_Y      = 479,
    parameter int DEATH_FRAMES = 60
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        start_key,
    input  logic        collision,
    input  logic        dead,
    input  logic        beat_monster,
    input  logic        hit,
    input  logic [9:0]  BallY,
    output logic [1:0]  game_state,
    output logic [13:0] score,
    output logic        jump_pulse,
    output logic        boost_pulse,
    output logic        monster_kill,
    output logic        freeze
`ifdef GAME_LIVES_EN
    ,
    output logic [1:0]  lives
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        DYING = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam int CNT_W = $clog2(DEATH_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [9:0]  FLOOR_LIM = 10'(FLOOR_Y);
    localparam logic [14:0] SAT_LIM   = 15'(SCORE_MAX);

    state_t           state, state_n;
    logic [13:0]      score_n;
    logic             jump_n, boost_n, kill_n;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
    logic             frame_s1, frame_s2, frame_q, frame_tick;
    logic             coll_q, start_q, start_rise;
    logic             land, kill, fall, death;
    logic [14:0]      pts, sum;

`ifdef GAME_LIVES_EN
    logic [1:0] lives_n;
    logic [5:0] inv_cnt, inv_n;
    logic       respawn;
`endif

    // frame_clk comes from another timing source, so it is synchronised before edge detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_s1 <= 1'b0;
            frame_s2 <= 1'b0;
            frame_q  <= 1'b0;
            start_q  <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            frame_s1 <= frame_clk;
            frame_s2 <= frame_s1;
            frame_q  <= frame_s2;
            start_q  <= start_key;
            if (frame_tick)
                coll_q <= collision;
        end
    end

    assign frame_tick = frame_s2 & ~frame_q;
    assign start_rise = start_key & ~start_q;
    assign land       = collision & ~coll_q;
    assign kill       = hit | beat_monster;
    assign fall       = BallY > FLOOR_LIM;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            score        <= '0;
            jump_pulse   <= 1'b0;
            boost_pulse  <= 1'b0;
            monster_kill <= 1'b0;
            frame_cnt    <= '0;
`ifdef GAME_LIVES_EN
            lives        <= 2'd3;
            inv_cnt      <= '0;
`endif
        end else begin
            state        <= state_n;
            score        <= score_n;
            jump_pulse   <= jump_n;
            boost_pulse  <= boost_n;
            monster_kill <= kill_n;
            frame_cnt    <= frame_cnt_n;
`ifdef GAME_LIVES_EN
            lives        <= lives_n;
            inv_cnt      <= inv_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        score_n     = score;
        jump_n      = 1'b0;
        boost_n     = 1'b0;
        kill_n      = 1'b0;
        frame_cnt_n = frame_cnt;
        death       = 1'b0;
        pts         = '0;
        sum         = '0;
`ifdef GAME_LIVES_EN
        lives_n     = lives;
        inv_n       = inv_cnt;
        respawn     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_n     = PLAY;
                    score_n     = '0;
                    frame_cnt_n = '0;
`ifdef GAME_LIVES_EN
                    lives_n     = 2'd3;
                    inv_n       = '0;
`endif
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    // a hit or stomp removes the monster, so it cannot also kill the doodler
`ifdef GAME_LIVES_EN
                    death = (dead & ~kill & (inv_cnt == 6'd0)) | fall;
                    if (inv_cnt != 6'd0)
                        inv_n = inv_cnt - 6'd1;
                    if (death && lives > 2'd1) begin
                        respawn = 1'b1;
                        lives_n = lives - 2'd1;
                        inv_n   = 6'd32;
                    end else if (death) begin
                        state_n = DYING;
                    end
                    jump_n = (land & ~kill & ~death) | respawn;
`else
                    death = (dead & ~kill) | fall;
                    if (death)
                        state_n = DYING;
                    jump_n = land & ~kill & ~death;
`endif
                    kill_n  = kill;
                    boost_n = beat_monster;
                    if (kill)
                        pts = 15'(MONSTER_PTS);
                    if (land && !death)
                        pts = pts + 15'(STAIR_PTS);
                    sum = {1'b0, score} + pts;
                    score_n = (sum > SAT_LIM) ? SAT_LIM[13:0] : sum[13:0];
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (frame_cnt == LAST_FRAME) begin
                        state_n     = OVER;
                        frame_cnt_n = '0;
                    end else begin
                        frame_cnt_n = frame_cnt + CNT_W'(1);
                    end
                end
            end
            OVER: begin
                if (start_rise)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign game_state = state;
    assign freeze     = (state != PLAY);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl (default build, lives feature disabled).
module tb_game_flow_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic        start_key;
    logic        collision;
    logic        dead;
    logic        beat_monster;
    logic        hit;
    logic [9:0]  BallY;
    logic [1:0]  game_state;
    logic [13:0] score;
    logic        jump_pulse;
    logic        boost_pulse;
    logic        monster_kill;
    logic        freeze;

    int passed = 0;
    int total  = 0;
    int jump_count;
    logic s_jump, s_boost, s_kill;

    game_flow_ctrl dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .start_key    (start_key),
        .collision    (collision),
        .dead         (dead),
        .beat_monster (beat_monster),
        .hit          (hit),
        .BallY        (BallY),
        .game_state   (game_state),
        .score        (score),
        .jump_pulse   (jump_pulse),
        .boost_pulse  (boost_pulse),
        .monster_kill (monster_kill),
        .freeze       (freeze)
    );

    always #5 Clk = ~Clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // One frame strobe; pulses are captured on the single Clk they are valid
    task automatic frame_step();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        s_jump  = jump_pulse;
        s_boost = boost_pulse;
        s_kill  = monster_kill;
        @(negedge Clk) frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic c, input logic d, input logic b, input logic h, input logic [9:0] y);
        collision    = c;
        dead         = d;
        beat_monster = b;
        hit          = h;
        BallY        = y;
    endtask

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        start_key = 1'b0;
        apply_stimulus(0, 0, 0, 0, 10'd100);
        repeat (3) @(posedge Clk);
        #1;
        check_output("reset_state", game_state, 2'b00);
        check_output("reset_score", score, 0);
        check_output("reset_freeze", freeze, 1);
        check_output("reset_pulses", {jump_pulse, boost_pulse, monster_kill}, 0);

        @(negedge Clk) Reset_n = 1'b1;
        @(negedge Clk) start_key = 1'b1;
        @(posedge Clk) #1;
        check_output("start_play", game_state, 2'b01);
        check_output("play_freeze", freeze, 0);
        @(negedge Clk) start_key = 1'b0;

        // stair held for five frames scores once
        apply_stimulus(1, 0, 0, 0, 10'd100);
        jump_count = 0;
        for (int i = 0; i < 5; i++) begin
            frame_step();
            jump_count += int'(s_jump);
        end
        check_output("held_stair_jumps", jump_count, 1);
        check_output("held_stair_score", score, 1);
        apply_stimulus(0, 0, 0, 0, 10'd100);
        frame_step();
        apply_stimulus(1, 0, 0, 0, 10'd100);
        frame_step();
        check_output("reland_jump", s_jump, 1);
        check_output("reland_score", score, 2);
        apply_stimulus(0, 0, 0, 0, 10'd100);
        frame_step();

        apply_stimulus(0, 1, 0, 1, 10'd100);
        frame_step();
        check_output("hit_dead_kill", s_kill, 1);
        check_output("hit_dead_score", score, 12);
        check_output("hit_dead_state", game_state, 2'b01);

        apply_stimulus(1, 0, 1, 0, 10'd100);
        frame_step();
        check_output("stomp_land_pulses", {s_jump, s_boost, s_kill}, 3'b011);
        check_output("stomp_land_score", score, 23);
        apply_stimulus(0, 0, 0, 0, 10'd100);
        frame_step();

        apply_stimulus(0, 0, 1, 1, 10'd100);
        frame_step();
        check_output("hit_beat_pulses", {s_jump, s_boost, s_kill}, 3'b011);
        check_output("hit_beat_score", score, 33);

        apply_stimulus(0, 0, 0, 0, 10'd480);
        frame_step();
        check_output("fall_dying", game_state, 2'b10);
        check_output("dying_freeze", freeze, 1);
        apply_stimulus(1, 1, 1, 1, 10'd100);
        for (int i = 0; i < 59; i++) frame_step();
        check_output("dying_59", game_state, 2'b10);
        check_output("dying_score_held", score, 33);
        start_key = 1'b1;
        frame_step();
        check_output("dying_60_over", game_state, 2'b11);
        apply_stimulus(0, 0, 0, 0, 10'd100);
        repeat (5) @(posedge Clk);
        #1;
        check_output("over_held_key", game_state, 2'b11);
        @(negedge Clk) start_key = 1'b0;
        @(negedge Clk) start_key = 1'b1;
        @(posedge Clk) #1;
        check_output("over_to_idle", game_state, 2'b00);
        check_output("idle_score_kept", score, 33);
        repeat (5) @(posedge Clk);
        #1;
        check_output("idle_no_skip", game_state, 2'b00);
        @(negedge Clk) start_key = 1'b0;
        @(negedge Clk) start_key = 1'b1;
        @(posedge Clk) #1;
        check_output("restart_play", game_state, 2'b01);
        check_output("restart_score", score, 0);
        @(negedge Clk) start_key = 1'b0;

        // 999 stomps + 5 landings = 9995
        apply_stimulus(0, 0, 1, 0, 10'd100);
        for (int i = 0; i < 999; i++) frame_step();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 0, 0, 0, 10'd100);
            frame_step();
            apply_stimulus(0, 0, 0, 0, 10'd100);
            frame_step();
        end
        check_output("preload_score", score, 9995);
        apply_stimulus(0, 0, 1, 0, 10'd100);
        frame_step();
        check_output("saturate_beat", score, 9999);
        apply_stimulus(1, 0, 0, 0, 10'd100);
        frame_step();
        check_output("saturate_land", score, 9999);
        check_output("saturate_jump", s_jump, 1);

        apply_stimulus(0, 1, 0, 0, 10'd100);
        frame_step();
        check_output("dead_dying", game_state, 2'b10);
        repeat (3) frame_step();
        #2 Reset_n = 1'b0;
        #1;
        check_output("async_reset_state", game_state, 2'b00);
        check_output("async_reset_score", score, 0);
        check_output("async_reset_pulses", {jump_pulse, boost_pulse, monster_kill, freeze}, 4'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
